// File: rtl/approx_pkg.sv
// approx_pkg: shared FSM state type and default speculative adder geometry
package approx_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK = 4;
  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;
endpackage

// File: rtl/spec_add_ctrl_if.sv
// spec_add_ctrl_if: operand/result handshake bundle for the speculative adder
interface spec_add_ctrl_if
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK = DEF_BLK
);
  localparam int NBLK = WIDTH / BLK;
  localparam int CW = $clog2(NBLK);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic err_flag;
  logic [CW-1:0] cycles;
  modport master (
    output in_valid, a, b, mode, out_ready,
    input in_ready, out_valid, sum, cout, err_flag, cycles
  );
  modport slave (
    input in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, cout, err_flag, cycles
  );
endinterface

// File: rtl/spec_block_adder.sv
// spec_block_adder: BLK-bit ripple adder block with carry in and carry out
module spec_block_adder #(
  parameter int BLK = 4
) (
  input logic [BLK-1:0] a,
  input logic [BLK-1:0] b,
  input logic cin,
  output logic [BLK-1:0] sum,
  output logic cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};
endmodule

// File: rtl/spec_add_ctrl.sv
// spec_add_ctrl: block-speculative adder with optional serial carry correction
module spec_add_ctrl
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK = DEF_BLK
) (
  input logic clk,
  input logic rst,
  spec_add_ctrl_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int CW = $clog2(NBLK);
  state_t state;
  logic [WIDTH-1:0] ra, rb, s;
  logic rmode, in_ready_q, out_valid_q, err_q, found;
  logic [CW-1:0] cyc;
  logic [NBLK-1:0] cin, cin_n, spec_c, bc;
  logic [NBLK-2:0] p;
  logic [NBLK-1:1] m, m_n;
  genvar i;
  for (i = 0; i < NBLK; i++) begin : g_blk
    spec_block_adder #(.BLK(BLK)) u_add (
      .a(ra[i*BLK +: BLK]),
      .b(rb[i*BLK +: BLK]),
      .cin(cin[i]),
      .sum(s[i*BLK +: BLK]),
      .cout(bc[i])
    );
    if (i == 0) begin : g_b0
      assign spec_c[i] = 1'b0;
    end else begin : g_bn
      assign spec_c[i] = bus.a[i*BLK-1] & bus.b[i*BLK-1];
      assign p[i-1] = &(ra[(i-1)*BLK +: BLK] ^ rb[(i-1)*BLK +: BLK]);
      assign m[i] = cin[i] ^ bc[i-1];
      assign m_n[i] = cin_n[i] ^ (p[i-1] ? cin_n[i-1] : bc[i-1]);
    end
  end
  always_comb begin
    cin_n = cin;
    found = 1'b0;
    for (int k = 1; k < NBLK; k++) begin
      cin_n[k] = (m[k] && !found) ? bc[k-1] : cin[k];
      found = found | m[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rmode <= 1'b0;
      cin <= '0;
      err_q <= 1'b0;
      cyc <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ra <= bus.a;
          rb <= bus.b;
          rmode <= bus.mode;
          cin <= spec_c;
          in_ready_q <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          err_q <= |m;
          cyc <= '0;
          state <= (!rmode || m == '0) ? DONE : CORR;
          out_valid_q <= !rmode || m == '0;
        end
        CORR: begin
          cin <= cin_n;
          cyc <= cyc + 1'b1;
          state <= (m_n == '0) ? DONE : CORR;
          out_valid_q <= m_n == '0;
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum = s;
  assign bus.cout = bc[NBLK-1];
  assign bus.err_flag = err_q;
  assign bus.cycles = cyc;
endmodule

// File: tb/tb_spec_add_ctrl.sv
// tb_spec_add_ctrl: directed self-checking bench for spec_add_ctrl
module tb_spec_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int nfail = 0;
  spec_add_ctrl_if bus ();
  spec_add_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk_idle_zero(input string nm);
    nchk++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL %s out_valid got %b want 0", nm, bus.out_valid); end
    nchk++; if (bus.sum !== 16'h0000) begin nfail++; $display("FAIL %s sum got %h want 0000", nm, bus.sum); end
    nchk++; if (bus.cout !== 1'b0) begin nfail++; $display("FAIL %s cout got %b want 0", nm, bus.cout); end
    nchk++; if (bus.err_flag !== 1'b0) begin nfail++; $display("FAIL %s err_flag got %b want 0", nm, bus.err_flag); end
    nchk++; if (bus.cycles !== 2'd0) begin nfail++; $display("FAIL %s cycles got %0d want 0", nm, bus.cycles); end
    nchk++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL %s in_ready got %b want 1", nm, bus.in_ready); end
  endtask
  task automatic run_txn(input string nm, input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                         input logic [15:0] es, input logic ec, input logic ee, input logic [1:0] ecy,
                         input int eedg, input int hold);
    int n;
    @(negedge clk);
    nchk++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL %s start in_ready got %b want 1", nm, bus.in_ready); end
    bus.a = ta;
    bus.b = tb_;
    bus.mode = tm;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.a = ~ta;
    bus.b = ~tb_;
    bus.mode = ~tm;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    nchk++; if (n != eedg) begin nfail++; $display("FAIL %s latency got %0d edges want %0d", nm, n, eedg); end
    nchk++; if (bus.sum !== es) begin nfail++; $display("FAIL %s sum got %h want %h", nm, bus.sum, es); end
    nchk++; if (bus.cout !== ec) begin nfail++; $display("FAIL %s cout got %b want %b", nm, bus.cout, ec); end
    nchk++; if (bus.err_flag !== ee) begin nfail++; $display("FAIL %s err_flag got %b want %b", nm, bus.err_flag, ee); end
    nchk++; if (bus.cycles !== ecy) begin nfail++; $display("FAIL %s cycles got %0d want %0d", nm, bus.cycles, ecy); end
    nchk++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL %s busy in_ready got %b want 0", nm, bus.in_ready); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      nchk++; if (bus.out_valid !== 1'b1) begin nfail++; $display("FAIL %s hold%0d out_valid got %b want 1", nm, k, bus.out_valid); end
      nchk++; if (bus.sum !== es) begin nfail++; $display("FAIL %s hold%0d sum got %h want %h", nm, k, bus.sum, es); end
      nchk++; if (bus.cycles !== ecy) begin nfail++; $display("FAIL %s hold%0d cycles got %0d want %0d", nm, k, bus.cycles, ecy); end
      nchk++; if (bus.err_flag !== ee) begin nfail++; $display("FAIL %s hold%0d err_flag got %b want %b", nm, k, bus.err_flag, ee); end
      nchk++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL %s hold%0d in_ready got %b want 0", nm, k, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    nchk++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL %s release out_valid got %b want 0", nm, bus.out_valid); end
    nchk++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL %s release in_ready got %b want 1", nm, bus.in_ready); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
  endtask
  task automatic test_exact();
    run_txn("exact_8p8", 16'h0008, 16'h0008, 1'b1, 16'h0010, 1'b0, 1'b0, 2'd0, 2, 0);
    run_txn("exact_ffp1", 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b1, 2'd2, 4, 0);
    run_txn("exact_nocarry", 16'h1234, 16'h4321, 1'b1, 16'h5555, 1'b0, 1'b0, 2'd0, 2, 0);
    run_txn("exact_0ff0", 16'h0FF0, 16'h0010, 1'b1, 16'h1000, 1'b0, 1'b1, 2'd2, 4, 0);
    run_txn("exact_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2'd0, 2, 0);
  endtask
  task automatic test_approx();
    run_txn("approx_ffp1", 16'h00FF, 16'h0001, 1'b0, 16'h00F0, 1'b0, 1'b1, 2'd0, 2, 0);
    run_txn("approx_8888", 16'h8888, 16'h8888, 1'b0, 16'h1110, 1'b1, 1'b0, 2'd0, 2, 0);
  endtask
  task automatic test_max_corr();
    run_txn("max_corr", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd3, 5, 0);
  endtask
  task automatic test_hold();
    run_txn("hold", 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b1, 2'd2, 4, 5);
  endtask
  task automatic test_reset_mid_corr();
    @(negedge clk);
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.mode = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL midcorr pre out_valid got %b want 0", bus.out_valid); end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_zero("midcorr_rst");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    run_txn("after_rst", 16'h1234, 16'h4321, 1'b1, 16'h5555, 1'b0, 1'b0, 2'd0, 2, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_exact();
    test_approx();
    test_max_corr();
    test_hold();
    test_reset_mid_corr();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/spec_add_ctrl.md
SPEC_ADD_CTRL -- requirements
Module: spec_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits.
REQ-002 Parameter: BLK, 4, speculative block width in bits; WIDTH SHALL be a multiple of BLK; NBLK = WIDTH/BLK.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: a, b  input  WIDTH  operands.
REQ-008 Port: mode  input  1  0 = approximate result, 1 = exact (corrected) result.
REQ-009 Port: out_valid  output  1  result held on outputs.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: sum  output  WIDTH  result.
REQ-012 Port: cout  output  1  carry-out of top block under its current carry-in.
REQ-013 Port: err_flag  output  1  initial speculative result was wrong (any block mispredicted).
REQ-014 Port: cycles  output  $clog2(NBLK)  number of correction cycles performed.

Function
REQ-015 Block 0 carry-in SHALL be 0; speculated carry-in of block i (i>=1) SHALL be a[i*BLK-1] & b[i*BLK-1].
REQ-016 Block i (i>=1) is in error when its current carry-in differs from the carry-out of block i-1 under block i-1's current carry-in; err mask = NBLK-1 bits.
REQ-017 FSM states: IDLE, CALC, CORR, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, latch a, b, mode; go CALC. in_ready SHALL be 0 in all other states.
REQ-019 CALC (one cycle): compute speculative sum and err mask; err_flag <= (mask != 0); cycles <= 0; go DONE if mode=0 or mask=0, else CORR.
REQ-020 CORR: each cycle, set the lowest erroneous block's carry-in to its true value, recompute that block's sum and cycles <= cycles+1; go DONE when the updated mask is 0.
REQ-021 CORR SHALL take at most NBLK-1 cycles; in mode=1 the final sum/cout SHALL equal a+b exactly.
REQ-022 In mode=0 sum SHALL be the speculative result, with cycles=0 and err_flag valid.
REQ-023 DONE: out_valid=1; sum, cout, err_flag, cycles held stable until out_ready=1; on out_ready go IDLE (out_valid=0 next cycle).
REQ-024 Latency: out_valid rises 2 edges after the accepting edge plus one per correction cycle; no new operand accepted while busy (single transaction in flight).
REQ-025 in_valid during CALC/CORR/DONE SHALL be ignored; operands/mode changing after acceptance SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, out_valid=0, sum=0, cout=0, err_flag=0, cycles=0, regardless of state (including mid-CORR or DONE awaiting out_ready); in_ready=1 in the following cycle.
REQ-027 rst SHALL have priority over all handshake inputs in the same cycle.

Structure
REQ-028 Shared package approx_pkg SHALL hold the FSM state enum and the default WIDTH/BLK constants.
REQ-029 One sub-module spec_block_adder (BLK-bit adder: a, b, cin -> sum, cout) SHALL be instantiated NBLK times; carry-in selection and correction logic stay in spec_add_ctrl.

Verification
REQ-030 mode=1, a=0x0008, b=0x0008 -> sum=0x0010, cout=0, err_flag=0, cycles=0, out_valid 2 edges after accept.
REQ-031 mode=1, a=0x00FF, b=0x0001 -> sum=0x0100, err_flag=1, cycles=2, out_valid 4 edges after accept.
REQ-032 mode=0, a=0x00FF, b=0x0001 -> sum=0x00F0, err_flag=1, cycles=0.
REQ-033 mode=1, a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, cycles=3 (maximum NBLK-1).
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 Assert rst during CORR (0xFFFF+0x0001, mode=1) -> next cycle IDLE, out_valid=0, all outputs 0; a following transaction completes correctly.
